mem_access_unit: RTL

- Memory-stage block that consumes the execute-stage result: ALU output used as address or passthrough value, forwarded funct3, instruction type, store operand and destination register.
- Converts LOAD/STORE ops into a req/gnt/rvalid data-memory transaction with byte enables and load extraction, and passes RTYPE/ITYPE/BRANCH results straight through.
- Feeds the writeback pipeline register through a valid/ready output slot.
- Backpressures the pipeline via in_ready.

---
 rtl/mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: turns LOAD/STORE ops into a req/gnt/rvalid data-memory
// transaction and passes ALU results through for all other instruction types.
// Results leave through a single valid/ready slot toward writeback.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in flight; may accept a new op when the slot frees
// REQ    | mem_req held high with stable address/enables until mem_gnt
// WAIT   | load granted; waiting for mem_rvalid
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_itype,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wb,
    output logic        out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [2:0]  IT_LOAD     = 3'b000;
    localparam logic [2:0]  IT_STORE    = 3'b010;
    localparam logic [2:0]  IT_RTYPE    = 3'b011;
    localparam logic [2:0]  IT_ITYPE    = 3'b001;
    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;

    logic [15:0] tmo_cnt;
    logic [16:0] tmo_inc;
    logic        tmo_hit;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        is_load_q;

    logic        accept;
    logic        is_load;
    logic        is_store;
    logic        f3_legal;
    logic        misaligned;
    logic        mem_legal;
    logic        mem_fault;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic        done_store;
    logic        done_load;
    logic        done_tmo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a grant or rvalid arriving on the limit cycle wins
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && mem_legal) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_nxt = is_load_q ? S_WAIT : S_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid || tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: handshake and completion strobes
    always_comb begin
        in_ready   = (state == S_IDLE) && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        done_store = (state == S_REQ) && mem_gnt && !is_load_q;
        done_load  = (state == S_WAIT) && mem_rvalid;
        done_tmo   = ((state == S_REQ) && !mem_gnt && tmo_hit) ||
                     ((state == S_WAIT) && !mem_rvalid && tmo_hit);
    end

    // Decode the incoming op: legality, alignment, byte enables and write data
    always_comb begin
        is_load  = (in_itype == IT_LOAD);
        is_store = (in_itype == IT_STORE);
        f3_legal = 1'b0;
        if (is_load) begin
            f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) ||
                       (in_funct3 == 3'b010) || (in_funct3 == 3'b100) ||
                       (in_funct3 == 3'b101);
        end else if (is_store) begin
            f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) ||
                       (in_funct3 == 3'b010);
        end
        misaligned = ((in_funct3[1:0] == 2'b01) && in_alu_out[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
        mem_legal  = (is_load || is_store) && f3_legal && !misaligned;
        mem_fault  = (is_load || is_store) && !(f3_legal && !misaligned);

        be_calc    = 4'b1111;
        wdata_calc = in_store_data;
        if (is_store) begin
            case (in_funct3[1:0])
                2'b00: begin
                    be_calc    = 4'b0001 << in_alu_out[1:0];
                    wdata_calc = {4{in_store_data[7:0]}};
                end
                2'b01: begin
                    be_calc    = 4'b0011 << in_alu_out[1:0];
                    wdata_calc = {2{in_store_data[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = in_store_data;
                end
            endcase
        end
    end

    // Load extraction: shift the addressed lane down, then size/sign-extend
    always_comb begin
        lane = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // Timeout counter; the incremented value is compared so the limit
    // equals the number of cycles spent in REQ+WAIT
    always_comb begin
        tmo_inc = {1'b0, tmo_cnt} + 17'd1;
        tmo_hit = (tmo_inc >= TIMEOUT_LIM);
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 16'd0;
        end else if (accept) begin
            tmo_cnt <= 16'd0;
        end else if ((state == S_REQ) || (state == S_WAIT)) begin
            tmo_cnt <= tmo_inc[15:0];
        end
    end

    // Capture the accepted memory op for extraction and fault reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= 32'd0;
            funct3_q  <= 3'd0;
            rd_q      <= 5'd0;
            is_load_q <= 1'b0;
        end else if (accept && mem_legal) begin
            addr_q    <= in_alu_out;
            funct3_q  <= in_funct3;
            rd_q      <= in_rd;
            is_load_q <= is_load;
        end
    end

    // Memory request channel; address/enables/data stay put until the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else if (accept && mem_legal) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {in_alu_out[31:2], 2'b00};
            mem_be    <= be_calc;
            mem_wdata <= wdata_calc;
        end else if ((state == S_REQ) && (mem_gnt || tmo_hit)) begin
            mem_req <= 1'b0;
        end
    end

    // Output slot toward writeback: load on a new result, else drain on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_rd    <= 5'd0;
            out_wb    <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept && !mem_legal) begin
            out_valid <= 1'b1;
            out_data  <= in_alu_out;
            out_rd    <= in_rd;
            out_wb    <= (in_itype == IT_RTYPE) || (in_itype == IT_ITYPE);
            out_err   <= mem_fault;
        end else if (done_store) begin
            out_valid <= 1'b1;
            out_data  <= 32'd0;
            out_rd    <= rd_q;
            out_wb    <= 1'b0;
            out_err   <= 1'b0;
        end else if (done_load) begin
            out_valid <= 1'b1;
            out_data  <= load_val;
            out_rd    <= rd_q;
            out_wb    <= 1'b1;
            out_err   <= 1'b0;
        end else if (done_tmo) begin
            out_valid <= 1'b1;
            out_data  <= addr_q;
            out_rd    <= rd_q;
            out_wb    <= 1'b0;
            out_err   <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
